operand_queue_ctrl: RTL and testbench

- Parametrised circular-buffer operand queue in front of the calculator ALU. Successor to the fixed 5x8 shifting queue.
- Exposes the two oldest entries as a concatenated operand pair.
- Executes four queue opcodes (push, replace-front, reduce-pair, pop) with occupancy tracking, full/empty flags and explicit overflow/underflow error reporting.
- Illegal operations are rejected without corrupting state.

---
 rtl/operand_queue_ctrl.sv | 151 +++++++++++++++
 tb/tb_operand_queue_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/operand_queue_ctrl.sv
// Circular-buffer operand queue feeding the calculator ALU: exposes the two
// oldest entries as an operand pair and executes push/replace/reduce/pop.
module operand_queue_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [1:0]          opcode,
  input  logic [DATA_W-1:0]   back,
  input  logic                err_clr,
  output logic [2*DATA_W-1:0] top_conc,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  output logic                pair_valid,
  output logic                ack,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_REPLACE = 2'b01,
    OP_REDUCE  = 2'b10,
    OP_POP     = 2'b11
  } op_e;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_OVER  = 2'b01;
  localparam logic [1:0] CODE_UNDER = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W-1:0]  head_d, tail_d, head_nx;
  logic [CNT_W-1:0]  count_d;
  logic              ack_d, err_d, we, legal;
  logic [1:0]        err_code_d, rej_code;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Masked operand pair: never expose entries beyond the current occupancy
  always_comb begin
    head_nx  = ptr_inc(head);
    top_conc = '0;
    if (count != '0)
      top_conc[2*DATA_W-1:DATA_W] = mem[head];
    if (count >= CNT_W'(2))
      top_conc[DATA_W-1:0] = mem[head_nx];
  end

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign pair_valid = (count >= CNT_W'(2));

  // Next-state: legality is judged on the pre-op count
  always_comb begin
    head_d     = head;
    tail_d     = tail;
    count_d    = count;
    err_d      = err;
    err_code_d = err_code;
    we         = 1'b0;
    legal      = 1'b0;
    rej_code   = CODE_NONE;

    if (op_valid) begin
      case (op_e'(opcode))
        OP_PUSH: begin
          if (count < CNT_W'(DEPTH)) begin
            legal   = 1'b1;
            we      = 1'b1;
            tail_d  = ptr_inc(tail);
            count_d = count + CNT_W'(1);
          end else begin
            rej_code = CODE_OVER;
          end
        end
        OP_REPLACE: begin
          if (count >= CNT_W'(1)) begin
            legal  = 1'b1;
            we     = 1'b1;
            head_d = ptr_inc(head);
            tail_d = ptr_inc(tail);
          end else begin
            rej_code = CODE_UNDER;
          end
        end
        OP_REDUCE: begin
          if (count >= CNT_W'(2)) begin
            legal   = 1'b1;
            we      = 1'b1;
            head_d  = ptr_inc(ptr_inc(head));
            tail_d  = ptr_inc(tail);
            count_d = count - CNT_W'(1);
          end else begin
            rej_code = CODE_UNDER;
          end
        end
        default: begin
          if (count >= CNT_W'(1)) begin
            legal   = 1'b1;
            head_d  = ptr_inc(head);
            count_d = count - CNT_W'(1);
          end else begin
            rej_code = CODE_UNDER;
          end
        end
      endcase
    end

    // A rejection takes priority over a simultaneous clear
    if (op_valid && !legal) begin
      err_d      = 1'b1;
      err_code_d = rej_code;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_code_d = CODE_NONE;
    end

    ack_d = legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      err_code <= CODE_NONE;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      head     <= head_d;
      tail     <= tail_d;
      count    <= count_d;
      ack      <= ack_d;
      err      <= err_d;
      err_code <= err_code_d;
      if (we) mem[tail] <= back;
    end
  end

endmodule

// File: tb/tb_operand_queue_ctrl.sv
// Scoreboard bench for operand_queue_ctrl (DEPTH=4, DATA_W=8): the driver
// queues hand-computed post-op state, a monitor compares it one cycle later.
module tb_operand_queue_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] PUSH = 2'b00, REPL = 2'b01, RED = 2'b10, POP = 2'b11;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                op_valid = 1'b0;
  logic [1:0]          opcode = 2'b00;
  logic [DATA_W-1:0]   back = '0;
  logic                err_clr = 1'b0;
  logic [2*DATA_W-1:0] top_conc;
  logic [CNT_W-1:0]    count;
  logic                full, empty, pair_valid, ack, err;
  logic [1:0]          err_code;

  typedef struct packed {
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] top;
    logic                full;
    logic                empty;
    logic                pv;
    logic                ack;
    logic                err;
    logic [1:0]          code;
  } obs_t;

  obs_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  operand_queue_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .back(back),
    .err_clr(err_clr), .top_conc(top_conc), .count(count), .full(full),
    .empty(empty), .pair_valid(pair_valid), .ack(ack), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the state expected after the edge
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [7:0] b, input logic clr, input string nm,
                      input int c, input logic [15:0] t, input logic a,
                      input logic e, input logic [1:0] ec);
    obs_t x;
    @(negedge clk);
    rst      = r;
    op_valid = v;
    opcode   = op;
    back     = b;
    err_clr  = clr;
    x.count  = CNT_W'(c);
    x.top    = t;
    x.full   = (c == int'(DEPTH));
    x.empty  = (c == 0);
    x.pv     = (c >= 2);
    x.ack    = a;
    x.err    = e;
    x.code   = ec;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: compare after each active edge whenever a response is owed
  initial begin
    obs_t  got, want;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = '{count, top_conc, full, empty, pair_valid, ack, err, err_code};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got cnt=%0d top=%h f=%b e=%b pv=%b ack=%b err=%b code=%b, want cnt=%0d top=%h f=%b e=%b pv=%b ack=%b err=%b code=%b",
                   nm, got.count, got.top, got.full, got.empty, got.pv, got.ack, got.err, got.code,
                   want.count, want.top, want.full, want.empty, want.pv, want.ack, want.err, want.code);
        end
      end
    end
  end

  initial begin
    int waited;
    //   rst v  op    back  clr  name            cnt top      ack err code
    step(1, 0, PUSH, 8'h00, 0, "reset",          0, 16'h0000, 0, 0, 2'b00);
    step(0, 1, PUSH, 8'h11, 0, "push11",         1, 16'h1100, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h22, 0, "push22",         2, 16'h1122, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h33, 0, "push33",         3, 16'h1122, 1, 0, 2'b00);
    step(0, 1, RED,  8'h33, 0, "reduce33",       2, 16'h3333, 1, 0, 2'b00);
    step(0, 1, POP,  8'h00, 0, "pop_to1",        1, 16'h3300, 1, 0, 2'b00);
    step(0, 0, PUSH, 8'h99, 0, "idle",           1, 16'h3300, 0, 0, 2'b00);
    step(0, 1, PUSH, 8'h44, 0, "push44",         2, 16'h3344, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h55, 0, "push55",         3, 16'h3344, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h66, 0, "push66_full",    4, 16'h3344, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h77, 0, "push_overflow",  4, 16'h3344, 0, 1, 2'b01);
    step(0, 0, PUSH, 8'h00, 0, "err_sticky",     4, 16'h3344, 0, 1, 2'b01);
    step(0, 0, PUSH, 8'h00, 1, "err_clr",        4, 16'h3344, 0, 0, 2'b00);
    // wrap-around through repeated REPLACE on a full queue
    step(1, 0, PUSH, 8'h00, 0, "reset2",         0, 16'h0000, 0, 0, 2'b00);
    step(0, 1, PUSH, 8'h01, 0, "push01",         1, 16'h0100, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h02, 0, "push02",         2, 16'h0102, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h03, 0, "push03",         3, 16'h0102, 1, 0, 2'b00);
    step(0, 1, PUSH, 8'h04, 0, "push04",         4, 16'h0102, 1, 0, 2'b00);
    step(0, 1, REPL, 8'h05, 0, "repl05",         4, 16'h0203, 1, 0, 2'b00);
    step(0, 1, REPL, 8'h06, 0, "repl06",         4, 16'h0304, 1, 0, 2'b00);
    step(0, 1, REPL, 8'h07, 0, "repl07",         4, 16'h0405, 1, 0, 2'b00);
    step(0, 1, REPL, 8'h08, 0, "repl08",         4, 16'h0506, 1, 0, 2'b00);
    step(0, 1, REPL, 8'h09, 0, "repl09",         4, 16'h0607, 1, 0, 2'b00);
    step(0, 1, POP,  8'h00, 0, "pop_a",          3, 16'h0708, 1, 0, 2'b00);
    step(0, 1, POP,  8'h00, 0, "pop_b",          2, 16'h0809, 1, 0, 2'b00);
    step(0, 1, POP,  8'h00, 0, "pop_c",          1, 16'h0900, 1, 0, 2'b00);
    step(0, 1, POP,  8'h00, 0, "pop_d",          0, 16'h0000, 1, 0, 2'b00);
    // underflow handling
    step(0, 1, POP,  8'h00, 0, "pop_underflow",  0, 16'h0000, 0, 1, 2'b10);
    step(0, 1, PUSH, 8'hAA, 0, "push_err_holds", 1, 16'hAA00, 1, 1, 2'b10);
    step(0, 1, RED,  8'hBB, 0, "reduce_under",   1, 16'hAA00, 0, 1, 2'b10);
    step(0, 1, REPL, 8'hCC, 0, "replace_at1",    1, 16'hCC00, 1, 1, 2'b10);
    step(0, 0, PUSH, 8'h00, 1, "err_clr2",       1, 16'hCC00, 0, 0, 2'b00);
    step(0, 1, RED,  8'h00, 1, "rej_beats_clr",  1, 16'hCC00, 0, 1, 2'b10);
    step(0, 1, PUSH, 8'hDD, 0, "pushDD",         2, 16'hCCDD, 1, 1, 2'b10);
    step(0, 1, PUSH, 8'hEE, 0, "pushEE",         3, 16'hCCDD, 1, 1, 2'b10);
    step(0, 1, PUSH, 8'hFF, 0, "pushFF",         4, 16'hCCDD, 1, 1, 2'b10);
    step(0, 1, PUSH, 8'h12, 1, "over_with_clr",  4, 16'hCCDD, 0, 1, 2'b01);
    step(0, 1, RED,  8'h13, 0, "reduce_full",    3, 16'hEEFF, 1, 1, 2'b01);
    // reset mid-sequence discards the op presented with it
    step(1, 1, PUSH, 8'h14, 0, "push_in_reset",  0, 16'h0000, 0, 0, 2'b00);
    step(0, 0, PUSH, 8'h00, 0, "post_reset",     0, 16'h0000, 0, 0, 2'b00);
    step(0, 1, PUSH, 8'h15, 0, "push15",         1, 16'h1500, 1, 0, 2'b00);
    step(0, 0, PUSH, 8'h00, 0, "final_idle",     1, 16'h1500, 0, 0, 2'b00);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
